// File: rtl/dcache_fill_fsm_pkg.sv
// Shared constants and state encoding for the D-cache block fill controller.
// Blocks are 16 bytes: eight 16-bit words addressed on even byte boundaries.
package cache_pkg;

    localparam int ADDR_WIDTH  = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/dcache_fill_fsm_if.sv
// Bundle of the miss, memory and array-write signals around the fill controller.
// The controller takes the master view; its environment takes the slave view.
interface dcache_fill_fsm_if
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH
);

    logic                          miss_detected;
    logic [ADDR_WIDTH-1:0]         miss_address;
    logic                          mem_grant;
    logic                          mem_data_valid;
    logic [15:0]                   mem_data;
    logic                          fsm_busy;
    logic                          D_miss;
    logic [ADDR_WIDTH-1:0]         memory_address;
    logic                          write_data_array;
    logic [WORD_IDX_W-1:0]         data_word_sel;
    logic [15:0]                   fill_data;
    logic                          write_tag_array;
    logic [ADDR_WIDTH-5:0]         fill_tag;
    logic                          txn_done;

    modport master (
        input  miss_detected, miss_address, mem_grant, mem_data_valid, mem_data,
        output fsm_busy, D_miss, memory_address, write_data_array, data_word_sel,
               fill_data, write_tag_array, fill_tag, txn_done
    );

    modport slave (
        output miss_detected, miss_address, mem_grant, mem_data_valid, mem_data,
        input  fsm_busy, D_miss, memory_address, write_data_array, data_word_sel,
               fill_data, write_tag_array, fill_tag, txn_done
    );

endinterface

// File: rtl/dcache_fill_fsm_word_counter.sv
// Word index counter for a block: counts 0..MAX_VAL, then raises a sticky
// done flag and holds at MAX_VAL so the last index stays visible.
module word_counter
    import cache_pkg::*;
#(
    parameter int W       = WORD_IDX_W,
    parameter int MAX_VAL = BLOCK_WORDS - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         done
);

    logic [W-1:0] cnt_r;
    logic         done_r;

    // Count register with clear taking priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= {W{1'b0}};
            done_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= {W{1'b0}};
            done_r <= 1'b0;
        end else if (en && !done_r) begin
            if (cnt_r == W'(MAX_VAL)) begin
                cnt_r  <= cnt_r;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + {{(W-1){1'b0}}, 1'b1};
                done_r <= done_r;
            end
        end else begin
            cnt_r  <= cnt_r;
            done_r <= done_r;
        end
    end

    assign cnt  = cnt_r;
    assign done = done_r;

endmodule

// File: rtl/dcache_fill_fsm.sv
// D-cache miss fill controller: issues the eight word addresses of the missing
// block, writes returning words into the data array, then commits the tag.
module dcache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_fill_fsm_if.master     bus
);

    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(BLOCK_WORDS - 1);

    fill_state_e                state_r;
    fill_state_e                state_s;
    logic [ADDR_WIDTH-5:0]      tag_r;
    logic                       txn_done_r;
    logic                       write_tag_r;

    logic [WORD_IDX_W-1:0]      iss_cnt_s;
    logic                       iss_done_s;
    logic [WORD_IDX_W-1:0]      rx_cnt_s;
    logic                       rx_done_s;

    logic                       in_fill_s;
    logic                       start_s;
    logic                       rx_last_s;
    logic                       cnt_clr_s;
    logic                       iss_en_s;
    logic                       rx_en_s;
    logic                       unused_addr_bits_s;

    assign in_fill_s = (state_r == ST_FILL);
    assign start_s   = (state_r == ST_IDLE) && bus.miss_detected;
    assign iss_en_s  = in_fill_s && bus.mem_grant && !iss_done_s;
    assign rx_en_s   = in_fill_s && bus.mem_data_valid && !rx_done_s;
    assign rx_last_s = rx_en_s && (rx_cnt_s == LAST_IDX);
    // Counters sit at zero whenever idle, so a new fill always starts at word 0.
    assign cnt_clr_s = !in_fill_s || rx_last_s;

    assign unused_addr_bits_s = ^bus.miss_address[3:0];

    word_counter #(.W(WORD_IDX_W), .MAX_VAL(BLOCK_WORDS - 1)) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (iss_en_s),
        .clr  (cnt_clr_s),
        .cnt  (iss_cnt_s),
        .done (iss_done_s)
    );

    word_counter #(.W(WORD_IDX_W), .MAX_VAL(BLOCK_WORDS - 1)) u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (rx_en_s),
        .clr  (cnt_clr_s),
        .cnt  (rx_cnt_s),
        .done (rx_done_s)
    );

    // Next-state logic: a miss starts a fill, the last returned word ends it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.miss_detected) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (rx_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, latched tag and the one-cycle completion strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            tag_r       <= {(ADDR_WIDTH-4){1'b0}};
            txn_done_r  <= 1'b0;
            write_tag_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            tag_r       <= start_s ? bus.miss_address[ADDR_WIDTH-1:4] : tag_r;
            txn_done_r  <= rx_last_s;
            write_tag_r <= rx_last_s;
        end
    end

    assign bus.fsm_busy         = in_fill_s;
    assign bus.D_miss           = in_fill_s;
    assign bus.memory_address   = {tag_r, iss_cnt_s, 1'b0};
    assign bus.write_data_array = in_fill_s && bus.mem_data_valid;
    assign bus.data_word_sel    = rx_cnt_s;
    assign bus.fill_data        = bus.mem_data;
    assign bus.write_tag_array  = write_tag_r;
    assign bus.fill_tag         = tag_r;
    assign bus.txn_done         = txn_done_r;

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Bench for dcache_fill_fsm: directed block-fill scenarios plus random traffic,
// compared each cycle against a transaction-level fill model and 4-cycle memory.
module tb_dcache_fill_fsm;

    logic clk;
    logic rst;

    dcache_fill_fsm_if #(.ADDR_WIDTH(16)) bus ();

    dcache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;
    int done_cyc;
    int miss_cyc;
    int due_q[$];

    // reference model: block fill as counts of words issued and received
    bit m_fill;
    bit m_pulse;
    int m_tag;
    int m_iss;
    int m_rcv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fill  = 1'b0;
        m_pulse = 1'b0;
        m_tag   = 0;
        m_iss   = 0;
        m_rcv   = 0;
        due_q.delete();
    endtask

    task automatic zero_checks(input string pfx);
        check_val({pfx, "_busy"}, 32'(bus.fsm_busy), 32'd0);
        check_val({pfx, "_dmiss"}, 32'(bus.D_miss), 32'd0);
        check_val({pfx, "_addr"}, 32'(bus.memory_address), 32'd0);
        check_val({pfx, "_wda"}, 32'(bus.write_data_array), 32'd0);
        check_val({pfx, "_sel"}, 32'(bus.data_word_sel), 32'd0);
        check_val({pfx, "_wta"}, 32'(bus.write_tag_array), 32'd0);
        check_val({pfx, "_tag"}, 32'(bus.fill_tag), 32'd0);
        check_val({pfx, "_done"}, 32'(bus.txn_done), 32'd0);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit miss, input logic [15:0] addr, input bit grant, input bit stray);
        bit          valid;
        logic [15:0] data;
        int          exp_addr;
        valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            valid = 1'b1;
            void'(due_q.pop_front());
        end else if (stray && !m_fill) begin
            valid = 1'b1;
        end
        data = 16'($urandom);
        bus.miss_detected  = miss;
        bus.miss_address   = addr;
        bus.mem_grant      = grant;
        bus.mem_data_valid = valid;
        bus.mem_data       = data;
        #1;
        exp_addr = (m_tag * 16) + (((m_iss > 7) ? 7 : m_iss) * 2);
        check_val("busy", 32'(bus.fsm_busy), 32'(m_fill));
        check_val("d_miss", 32'(bus.D_miss), 32'(m_fill));
        if (m_fill) check_val("mem_addr", 32'(bus.memory_address), 32'(exp_addr));
        check_val("wr_data", 32'(bus.write_data_array), 32'(m_fill && valid));
        if (m_fill && valid) begin
            check_val("word_sel", 32'(bus.data_word_sel), 32'(m_rcv));
            check_val("fill_data", 32'(bus.fill_data), 32'(data));
        end
        check_val("wr_tag", 32'(bus.write_tag_array), 32'(m_pulse));
        check_val("txn_done", 32'(bus.txn_done), 32'(m_pulse));
        check_val("fill_tag", 32'(bus.fill_tag), 32'(m_tag));
        if (bus.txn_done) done_cyc = cyc;
        if (m_fill) begin
            m_pulse = 1'b0;
            if (grant && m_iss < 8) begin
                m_iss++;
                due_q.push_back(cyc + 4);
            end
            if (valid) begin
                m_rcv++;
                if (m_rcv == 8) begin
                    m_fill  = 1'b0;
                    m_iss   = 0;
                    m_rcv   = 0;
                    m_pulse = 1'b1;
                end
            end
        end else begin
            m_pulse = 1'b0;
            if (miss) begin
                m_fill = 1'b1;
                m_tag  = int'(addr[15:4]);
                m_iss  = 0;
                m_rcv  = 0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b1, stray);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        done_cyc = -1;
        model_reset();
        rst                = 1'b0;
        bus.miss_detected  = 1'b0;
        bus.miss_address   = 16'h0000;
        bus.mem_grant      = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data       = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        zero_checks("reset");
        rst = 1'b1;

        // nominal fill right after reset release
        done_cyc = -1;
        miss_cyc = cyc;
        step(1'b1, 16'h1236, 1'b1, 1'b0);
        idle_cycles(18, 1'b0);
        check_val("latency_nominal", 32'(done_cyc - miss_cyc), 32'd13);
        check_val("tag_nominal", 32'(bus.fill_tag), 32'h123);

        // grant withdrawn in fill cycles 3..5
        done_cyc = -1;
        miss_cyc = cyc;
        step(1'b1, 16'h1236, 1'b1, 1'b0);
        for (int k = 1; k <= 22; k++) step(1'b0, 16'h0000, !(k >= 3 && k <= 5), 1'b0);
        check_val("latency_stall", 32'(done_cyc - miss_cyc), 32'd16);

        // a second miss during a fill is ignored
        step(1'b1, 16'h1230, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) step(k >= 2 && k <= 6, 16'h4000, 1'b1, 1'b0);
        check_val("tag_ignore_miss", 32'(bus.fill_tag), 32'h123);
        check_val("idle_after_ignore", 32'(bus.fsm_busy), 32'd0);

        // back-to-back: new miss in the txn_done cycle
        step(1'b1, 16'h1230, 1'b1, 1'b0);
        for (int k = 0; k < 30 && !m_pulse; k++) step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h2000, 1'b1, 1'b0);
        check_val("b2b_busy", 32'(bus.fsm_busy), 32'd1);
        check_val("b2b_addr", 32'(bus.memory_address), 32'h2000);
        idle_cycles(16, 1'b0);

        // asynchronous reset after the 4th strobe of a fill
        step(1'b1, 16'h1230, 1'b1, 1'b0);
        for (int k = 0; k < 30 && m_rcv < 4; k++) step(1'b0, 16'h0000, 1'b1, 1'b0);
        bus.mem_data_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        zero_checks("midfill_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(3, 1'b0);
        step(1'b1, 16'h5678, 1'b1, 1'b0);
        idle_cycles(16, 1'b0);

        // stray data strobes while idle
        idle_cycles(5, 1'b1);
        step(1'b1, 16'h9abc, 1'b1, 1'b0);
        idle_cycles(16, 1'b1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
